// File: rtl/uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deser
// Purpose  : UART receiver. Synchronises the asynchronous rx pin, detects
//            start bits and samples each bit at mid-period (LSB first). It
//            presents each byte through a single-entry ready/valid output
//            register. A byte that has a framing, parity or overrun error is
//            dropped, and the error is reported as a one-cycle pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   datawidth_p     data bits per frame
//   clks_per_bit_p  clk_i cycles per bit period (>= 4)
// Ports
//   clk_i           clock
//   rst_i           asynchronous active-high reset
//   rx_serial_i     UART line, idle high, asynchronous to clk_i
//   rx_data_o       received byte, stable while rx_valid_o is high
//   rx_valid_o      byte available
//   rx_ready_i      consumer accepts the byte when high together with valid
//   frame_err_o     pulse: stop bit sampled low
//   overrun_err_o   pulse: byte completed while output register still full
//   parity_err_o    pulse: even-parity mismatch (0 when parity compiled out)
//   busy_o          receiver is inside a frame
// Build option
//   UART_RX_PARITY_EN  when defined, one even-parity bit follows the data bits
// ============================================================================
module uart_rx_deser #(
  parameter int datawidth_p    = 8,
  parameter int clks_per_bit_p = 868
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_serial_i,
  output logic [datawidth_p-1:0] rx_data_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic                   frame_err_o,
  output logic                   overrun_err_o,
  output logic                   parity_err_o,
  output logic                   busy_o
);

  localparam int CNT_W = $clog2(clks_per_bit_p);
  localparam int IDX_W = (datawidth_p > 1) ? $clog2(datawidth_p) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((clks_per_bit_p - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(clks_per_bit_p - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(datawidth_p - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_t;

  state_t                 state, state_d;
  logic [CNT_W-1:0]       clk_cnt, clk_cnt_d;
  logic [IDX_W-1:0]       bit_idx, bit_idx_d;
  logic [datawidth_p-1:0] shift, shift_d;
  logic [datawidth_p:0]   shift_in;
  logic                   sync1, sync2, prev, falling;
  logic [1:0]             warm;
  logic                   load, frame_err_d, overrun_err_d, parity_err_d;
  logic                   parity_bad, out_free;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit, par_bit_d;
`endif

  // Synchroniser flops reset to idle (high). The warm-up shifter keeps
  // prev low until sync2 carries a genuine pin sample. A line that is
  // already low at reset release therefore never looks like a falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b0;
      warm  <= 2'b00;
    end else begin
      sync1 <= rx_serial_i;
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
      prev  <= sync2 & warm[1];
    end
  end

  assign falling  = prev & ~sync2;
  // New bits enter at the MSB, so after datawidth_p samples the first bit
  // (the LSB on the wire) sits in bit 0.
  assign shift_in = {sync2, shift};
  assign out_free = ~rx_valid_o | rx_ready_i;
`ifdef UART_RX_PARITY_EN
  assign parity_bad = ^{shift, par_bit};
`else
  assign parity_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= StIdle;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      clk_cnt <= clk_cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_bit_d;
`endif
    end
  end

  always_comb begin
    state_d       = state;
    clk_cnt_d     = clk_cnt;
    bit_idx_d     = bit_idx;
    shift_d       = shift;
`ifdef UART_RX_PARITY_EN
    par_bit_d     = par_bit;
`endif
    load          = 1'b0;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    parity_err_d  = 1'b0;
    case (state)
      StIdle: begin
        if (falling) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (clk_cnt == HALF_CNT) begin
          clk_cnt_d = '0;
          // If the line is high again at mid-start, treat it as a glitch.
          state_d   = sync2 ? StIdle : StData;
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end
      StData: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_d = '0;
          shift_d   = shift_in[datawidth_p:1];
          bit_idx_d = bit_idx + IDX_W'(1);
          if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_d = '0;
          par_bit_d = sync2;
          state_d   = StStop;
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end
`endif
      StStop: begin
        if (clk_cnt == LAST_CNT) begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          clk_cnt_d = '0;
          state_d   = StIdle;
          if (!sync2)         frame_err_d   = 1'b1;
          else if (parity_bad) parity_err_d  = 1'b1;
          else if (out_free)   load          = 1'b1;
          else                 overrun_err_d = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Single-entry output register. A load in the same cycle as a handshake
  // keeps valid high with the new byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
      parity_err_o  <= 1'b0;
    end else begin
      frame_err_o   <= frame_err_d;
      overrun_err_o <= overrun_err_d;
      parity_err_o  <= parity_err_d;
      if (load) begin
        rx_data_o  <= shift;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state != StIdle);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deser
// Purpose  : Self-checking bench for uart_rx_deser (clks_per_bit_p = 16).
//            Each delivered byte is pushed to a scoreboard queue when its
//            frame is driven. The queue is popped at every handshake.
//            Error pulses and deliveries are counted by a monitor and
//            checked per test step.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deser;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err, parity_err, busy;

  uart_rx_deser #(.datawidth_p(8), .clks_per_bit_p(CPB)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_serial_i  (rx),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (ready),
    .frame_err_o  (frame_err),
    .overrun_err_o(overrun_err),
    .parity_err_o (parity_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_flip;
    logic       deliver;
    int         exp_fe;
    int         exp_pe;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int compared = 0, mismatched = 0;
  int fe_cnt = 0, oe_cnt = 0, pe_cnt = 0, deliv_cnt = 0;
  bit busy_seen = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // The monitor samples on the falling edge. Inputs change 1 time unit
  // after the rising edge, so the values seen here match the values at
  // the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err)   fe_cnt++;
      if (overrun_err) oe_cnt++;
      if (parity_err)  pe_cnt++;
      if (busy)        busy_seen = 1'b1;
      if (rx_valid && ready) begin
        deliv_cnt++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_byte: got %02h, required none", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            mismatched++;
            $display("FAIL byte_data: got %02h, required %02h", rx_data, e);
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    send_bit(stop);
    rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fe0, oe0, pe0, d0;

    vecs.push_back('{8'hA5, 1'b1, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'h80, 1'b1, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'h55, 1'b0, 1'b0, 1'b0, 1, 0});
    vecs.push_back('{8'h01, 1'b1, 1'b0, 1'b1, 0, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h03, 1'b1, 1'b1, 1'b0, 0, 1});
    vecs.push_back('{8'h03, 1'b1, 1'b0, 1'b1, 0, 0});
`endif

    // Reset values
    cycles(3);
    check("reset_state", int'({rx_data, rx_valid, frame_err, overrun_err, parity_err, busy}), 0);

    // A line that is already low at reset release is not a start bit.
    rst = 1'b1;
    rx  = 1'b0;
    cycles(3);
    rst = 1'b0;
    busy_seen = 1'b0;
    cycles(40);
    check("low_at_release_busy", int'(busy_seen), 0);
    rx = 1'b1;
    cycles(10);

    // Table-driven frames with the consumer always ready.
    foreach (vecs[k]) begin
      fe0 = fe_cnt; pe0 = pe_cnt; d0 = deliv_cnt;
      if (vecs[k].deliver) exp_q.push_back(vecs[k].data);
      send_frame(vecs[k].data, vecs[k].stop, (^vecs[k].data) ^ vecs[k].par_flip);
      cycles(4);
      check($sformatf("frame_err_%0d", k), fe_cnt - fe0, vecs[k].exp_fe);
      check($sformatf("parity_err_%0d", k), pe_cnt - pe0, vecs[k].exp_pe);
      check($sformatf("delivered_%0d", k), deliv_cnt - d0, int'(vecs[k].deliver));
      check($sformatf("idle_%0d", k), int'(busy), 0);
    end

    // Overrun: two back-to-back frames while the consumer is stalled.
    ready = 1'b0;
    oe0 = oe_cnt; d0 = deliv_cnt;
    exp_q.push_back(8'h10);
    send_frame(8'h10, 1'b1, ^8'h10);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    cycles(4);
    check("overrun_valid_held", int'(rx_valid), 1);
    check("overrun_data_held", int'(rx_data), 8'h10);
    check("overrun_pulses", oe_cnt - oe0, 1);
    ready = 1'b1;
    cycles(3);
    check("overrun_valid_drop", int'(rx_valid), 0);
    check("overrun_delivered", deliv_cnt - d0, 1);

    // Throughput: three frames with no idle gap.
    d0 = deliv_cnt; oe0 = oe_cnt;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    send_frame(8'h11, 1'b1, ^8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    send_frame(8'h33, 1'b1, ^8'h33);
    cycles(4);
    check("b2b_delivered", deliv_cnt - d0, 3);
    check("b2b_no_overrun", oe_cnt - oe0, 0);

    // Short low glitch on an idle line.
    fe0 = fe_cnt; oe0 = oe_cnt; pe0 = pe_cnt; d0 = deliv_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    cycles(30);
    check("glitch_busy_seen", int'(busy_seen), 1);
    check("glitch_busy_low", int'(busy), 0);
    check("glitch_no_byte", deliv_cnt - d0, 0);
    check("glitch_no_err", (fe_cnt - fe0) + (oe_cnt - oe0) + (pe_cnt - pe0), 0);

    // Asynchronous reset in the middle of a data bit of 0xFF.
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    cycles(8);
    #2 rst = 1'b1;
    #1;
    check("midframe_reset_outputs",
          int'({rx_data, rx_valid, frame_err, overrun_err, parity_err, busy}), 0);
    cycles(3);
    rst = 1'b0;
    cycles(5);
    d0 = deliv_cnt;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, ^8'h7E);
    cycles(4);
    check("after_reset_delivered", deliv_cnt - d0, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
